wash_sequencer: RTL and testbench

- Top-level program controller for the washer datapath.
- Sequences the full program: fill, then WASH_CYCLES rounds of (forward run, pause, reverse run, pause), then drain, spin and done.
- Drives motor direction, water valves and phase/countdown status for the display block.
- All timing counts one-second enable ticks from the shared prescaler; there are no free-running counters on clk.

---
 rtl/wash_sequencer_if.sv | 38 +++
 rtl/wash_sequencer.sv | 139 +++++++++++++
 tb/tb_wash_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_sequencer_if.sv
// Control inputs and status/drive outputs of the washer program sequencer.
// WASH_SEQ_BUZZER_EN adds the end-of-program buzzer line.
interface wash_sequencer_if;
    logic       tick_1s;
    logic       start;
    logic       stop;
    logic       hold;
    logic       motor_fwd;
    logic       motor_rev;
    logic       valve_in;
    logic       valve_out;
    logic [3:0] phase;
    logic [5:0] sec_left;
    logic [3:0] cycle_left;
    logic       busy;
    logic       done;
`ifdef WASH_SEQ_BUZZER_EN
    logic       buzzer;
`endif

    modport master (
        output tick_1s, start, stop, hold,
`ifdef WASH_SEQ_BUZZER_EN
        input  buzzer,
`endif
        input  motor_fwd, motor_rev, valve_in, valve_out,
        input  phase, sec_left, cycle_left, busy, done
    );

    modport slave (
        input  tick_1s, start, stop, hold,
`ifdef WASH_SEQ_BUZZER_EN
        output buzzer,
`endif
        output motor_fwd, motor_rev, valve_in, valve_out,
        output phase, sec_left, cycle_left, busy, done
    );
endinterface

// File: rtl/wash_sequencer.sv
// Washer program controller: fill, WASH_CYCLES x (fwd, pause, rev, pause), drain, spin, done; timed in tick_1s.
// Optional macro WASH_SEQ_BUZZER_EN adds a buzzer output high for the first 3 ticks of DONE.
module wash_sequencer #(
    parameter int FILL_S      = 10,
    parameter int RUN_S       = 25,
    parameter int PAUSE_S     = 5,
    parameter int WASH_CYCLES = 4,
    parameter int DRAIN_S     = 10,
    parameter int SPIN_S      = 20
) (
    input  logic             clk,
    input  logic             rst,
    wash_sequencer_if.slave  bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FILL    = 4'd1,
        S_FWD     = 4'd2,
        S_PAUSE_A = 4'd3,
        S_REV     = 4'd4,
        S_PAUSE_B = 4'd5,
        S_DRAIN   = 4'd6,
        S_SPIN    = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t     state, nxt_state;
    logic [5:0] sec_q, nxt_sec;
    logic [3:0] cyc_q, nxt_cyc;
    logic       fwd_q, rev_q, vin_q, vout_q, busy_q, done_q;
    logic       busy_now, drv_en;

    function automatic logic [5:0] dur(input state_t s);
        case (s)
            S_FILL:              return 6'(FILL_S);
            S_FWD, S_REV:        return 6'(RUN_S);
            S_PAUSE_A, S_PAUSE_B: return 6'(PAUSE_S);
            S_DRAIN:             return 6'(DRAIN_S);
            S_SPIN:              return 6'(SPIN_S);
            default:             return 6'd0;
        endcase
    endfunction

    assign busy_now = (state != S_IDLE) && (state != S_DONE);
    // Drives drop while a running program is held; stop lands in IDLE so it is covered by decode.
    assign drv_en   = !(busy_now && bus.hold);

    always_comb begin
        nxt_state = state;
        nxt_sec   = sec_q;
        nxt_cyc   = cyc_q;
        if (bus.stop) begin
            nxt_state = S_IDLE;
            nxt_sec   = 6'd0;
            nxt_cyc   = 4'd0;
        end else if (!busy_now) begin
            if (bus.start && !bus.hold) begin
                nxt_state = S_FILL;
                nxt_sec   = dur(S_FILL);
                nxt_cyc   = 4'(WASH_CYCLES);
            end
        end else if (!bus.hold && bus.tick_1s) begin
            if (sec_q > 6'd1) begin
                nxt_sec = sec_q - 6'd1;
            end else begin
                case (state)
                    S_FILL:    nxt_state = S_FWD;
                    S_FWD:     nxt_state = S_PAUSE_A;
                    S_PAUSE_A: nxt_state = S_REV;
                    S_REV:     nxt_state = S_PAUSE_B;
                    S_PAUSE_B: begin
                        if (cyc_q > 4'd1) begin
                            nxt_state = S_FWD;
                            nxt_cyc   = cyc_q - 4'd1;
                        end else begin
                            nxt_state = S_DRAIN;
                            nxt_cyc   = 4'd0;
                        end
                    end
                    S_DRAIN:   nxt_state = S_SPIN;
                    S_SPIN:    nxt_state = S_DONE;
                    default:   nxt_state = S_IDLE;
                endcase
                nxt_sec = dur(nxt_state);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            sec_q  <= 6'd0;
            cyc_q  <= 4'd0;
            fwd_q  <= 1'b0;
            rev_q  <= 1'b0;
            vin_q  <= 1'b0;
            vout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= nxt_state;
            sec_q  <= nxt_sec;
            cyc_q  <= nxt_cyc;
            fwd_q  <= drv_en && (nxt_state == S_FWD || nxt_state == S_SPIN);
            rev_q  <= drv_en && (nxt_state == S_REV);
            vin_q  <= drv_en && (nxt_state == S_FILL);
            vout_q <= drv_en && (nxt_state == S_DRAIN || nxt_state == S_SPIN);
            busy_q <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done_q <= (nxt_state == S_DONE);
        end
    end

    assign bus.phase      = state;
    assign bus.sec_left   = sec_q;
    assign bus.cycle_left = cyc_q;
    assign bus.motor_fwd  = fwd_q;
    assign bus.motor_rev  = rev_q;
    assign bus.valve_in   = vin_q;
    assign bus.valve_out  = vout_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

`ifdef WASH_SEQ_BUZZER_EN
    // Loaded on DONE entry; the entering tick itself is not one of the three.
    logic [1:0] buzz_cnt;

    always_ff @(posedge clk) begin
        if (rst || nxt_state != S_DONE) begin
            buzz_cnt <= 2'd0;
        end else if (state != S_DONE) begin
            buzz_cnt <= 2'd3;
        end else if (bus.tick_1s && buzz_cnt != 2'd0) begin
            buzz_cnt <= buzz_cnt - 2'd1;
        end
    end

    assign bus.buzzer = (buzz_cnt != 2'd0);
`endif
endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: stimulus queues expected phase entries and snapshots,
// a monitor pops and compares them as the DUT changes phase or a snapshot is requested.
module tb_wash_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic mon_en = 1'b0;
    logic end_req = 1'b0;

    always #5 clk = ~clk;

    wash_sequencer_if bus();

    wash_sequencer #(
        .FILL_S(2), .RUN_S(3), .PAUSE_S(1), .WASH_CYCLES(2), .DRAIN_S(2), .SPIN_S(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] ph;
        logic [5:0] sec;
        logic [3:0] cyc;
        logic [3:0] drv;
        logic       busy;
        logic       done;
        logic       buz;
        int         stamp;
    } rec_t;

    rec_t trans_q[$];
    rec_t snap_q[$];
    int total = 0;
    int bad = 0;
    int tick_num = 0;
    int snap_cnt = 0;
    int snap_seen = 0;

    localparam int NPROG = 12;
    int prog_ph [NPROG] = '{1, 2, 3, 4, 5, 2, 3, 4, 5, 6, 7, 8};
    int prog_cyc[NPROG] = '{2, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0};
    int prog_cum[NPROG] = '{0, 2, 5, 6, 9, 10, 13, 14, 17, 18, 20, 22};

    function automatic int dur(input int ph);
        case (ph)
            1:       return 2;
            2, 4:    return 3;
            3, 5:    return 1;
            6, 7:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic rec_t mk(input int ph, input int sec, input int cyc, input int stamp);
        rec_t r;
        r.ph    = 4'(ph);
        r.sec   = 6'(sec);
        r.cyc   = 4'(cyc);
        r.drv   = {(ph == 2 || ph == 7), (ph == 4), (ph == 1), (ph == 6 || ph == 7)};
        r.busy  = (ph != 0) && (ph != 8);
        r.done  = (ph == 8);
        r.buz   = (ph == 8);
        r.stamp = stamp;
        return r;
    endfunction

    task automatic push_prog(input int first, input int last, input int base);
        for (int i = first; i <= last; i++)
            trans_q.push_back(mk(prog_ph[i], dur(prog_ph[i]), prog_cyc[i], base + prog_cum[i]));
    endtask

    task automatic snap(input rec_t r);
        snap_q.push_back(r);
        snap_cnt++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        bus.tick_1s = 1'b1;
        tick_num++;
        step(1);
        bus.tick_1s = 1'b0;
        step(3);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input rec_t e, input string nm);
        rec_t a;
        a.ph   = bus.phase;
        a.sec  = bus.sec_left;
        a.cyc  = bus.cycle_left;
        a.drv  = {bus.motor_fwd, bus.motor_rev, bus.valve_in, bus.valve_out};
        a.busy = bus.busy;
        a.done = bus.done;
`ifdef WASH_SEQ_BUZZER_EN
        a.buz  = bus.buzzer;
`else
        a.buz  = e.buz;
`endif
        a.stamp = (e.stamp == -1) ? -1 : tick_num;
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got ph=%0d sec=%0d cyc=%0d drv=%b busy=%b done=%b buz=%b tick=%0d, want ph=%0d sec=%0d cyc=%0d drv=%b busy=%b done=%b buz=%b tick=%0d",
                     nm, a.ph, a.sec, a.cyc, a.drv, a.busy, a.done, a.buz, a.stamp,
                     e.ph, e.sec, e.cyc, e.drv, e.busy, e.done, e.buz, e.stamp);
        end
    endtask

    initial begin : monitor
        logic [3:0] last_ph;
        rec_t       e;
        bit         fin_done;
        last_ph  = 4'd0;
        fin_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                total++;
                if (bus.motor_fwd && bus.motor_rev) begin
                    bad++;
                    $display("FAIL motor_excl: got fwd=%b rev=%b, want not both 1", bus.motor_fwd, bus.motor_rev);
                end
                if (bus.phase !== last_ph) begin
                    last_ph = bus.phase;
                    if (trans_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_transition: got ph=%0d, want no change", bus.phase);
                    end else begin
                        e = trans_q.pop_front();
                        check(e, "transition");
                    end
                end
                if (snap_seen != snap_cnt) begin
                    snap_seen++;
                    e = snap_q.pop_front();
                    check(e, "snapshot");
                end
                if (end_req && !fin_done) begin
                    fin_done = 1'b1;
                    total++;
                    if (trans_q.size() != 0) begin
                        bad++;
                        $display("FAIL missing_transitions: got %0d pending, want 0", trans_q.size());
                    end
                end
            end
        end
    end

    initial begin : stimulus
        rec_t r;
        int   base;
        rst = 1'b1;
        bus.tick_1s = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.hold = 1'b0;
        step(3);
        rst = 1'b0;
        mon_en = 1'b1;
        snap(mk(0, 0, 0, -1));
        step(1);

        // hold in IDLE blocks start
        bus.hold = 1'b1;
        bus.start = 1'b1;
        step(2);
        snap(mk(0, 0, 0, -1));
        step(1);
        bus.hold = 1'b0;
        bus.start = 1'b0;
        step(1);

        // full program, with a start pulse while busy that must be ignored
        push_prog(0, NPROG - 1, tick_num);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(3);
        ticks(3);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        ticks(19);
        snap(mk(8, 0, 0, -1));
        step(1);
        tick();
        snap(mk(8, 0, 0, -1));
        step(1);
        tick();
        snap(mk(8, 0, 0, -1));
        step(1);
        tick();
        r = mk(8, 0, 0, -1);
        r.buz = 1'b0;
        snap(r);
        step(1);

        // level-held start restarts from DONE; hold in REV at sec_left=2
        base = tick_num;
        push_prog(0, 3, base);
        bus.start = 1'b1;
        step(3);
        bus.start = 1'b0;
        step(1);
        ticks(7);
        snap(mk(4, 2, 2, -1));
        step(1);
        bus.hold = 1'b1;
        step(1);
        r = mk(4, 2, 2, -1);
        r.drv = 4'b0000;
        snap(r);
        step(1);
        ticks(5);
        snap(r);
        step(1);
        bus.hold = 1'b0;
        step(1);
        snap(mk(4, 2, 2, -1));
        step(1);
        trans_q.push_back(mk(5, 1, 2, tick_num + 2));
        tick();
        snap(mk(4, 1, 2, -1));
        step(1);
        tick();

        // stop + start + tick together in FWD
        trans_q.push_back(mk(2, 3, 1, tick_num + 1));
        tick();
        trans_q.push_back(mk(0, 0, 0, tick_num + 1));
        bus.stop = 1'b1;
        bus.start = 1'b1;
        bus.tick_1s = 1'b1;
        tick_num++;
        step(1);
        bus.stop = 1'b0;
        bus.start = 1'b0;
        bus.tick_1s = 1'b0;
        snap(mk(0, 0, 0, -1));
        step(1);
        trans_q.push_back(mk(1, 2, 2, tick_num));
        step(2);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(1);

        // back to IDLE, then start coincident with a tick
        trans_q.push_back(mk(0, 0, 0, tick_num));
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        step(2);
        tick_num++;
        push_prog(0, 10, tick_num);
        bus.start = 1'b1;
        bus.tick_1s = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.tick_1s = 1'b0;
        step(3);
        snap(mk(1, 2, 2, -1));
        step(1);
        tick();
        snap(mk(1, 1, 2, -1));
        step(1);
        ticks(19);
        tick();
        snap(mk(7, 1, 0, -1));
        step(1);

        // reset mid-SPIN
        trans_q.push_back(mk(0, 0, 0, tick_num));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);

        // stop while buzzing in DONE
        push_prog(0, NPROG - 1, tick_num);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(3);
        ticks(22);
        tick();
        snap(mk(8, 0, 0, -1));
        step(1);
        trans_q.push_back(mk(0, 0, 0, tick_num));
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        snap(mk(0, 0, 0, -1));
        step(2);

        end_req = 1'b1;
        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
